// File: rtl/rf_sequencer_if.sv
`default_nettype none
// ============================================================================
// rf_sequencer_if : command and response valid/ready channels of rf_sequencer
// Revision 1.0
// ============================================================================
interface rf_sequencer_if #(
    parameter int W     = 16,
    parameter int IMM_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [2:0]       cmd_rd;
    logic [2:0]       cmd_rs;
    logic [IMM_W-1:0] cmd_imm;
    logic [1:0]       cmd_sh;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm, cmd_sh, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm, cmd_sh, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/rf_sequencer.sv
`default_nettype none
// ============================================================================
// rf_sequencer : sequences MOVI/MOV/SWAP/READ commands into 8x16 regfile cycles
// Optional build macro RF_SEQ_SHIFT_EN adds a shift stage to MOV.
// Revision 1.0
// ============================================================================
module rf_sequencer #(
    parameter int W     = 16,
    parameter int IMM_W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    rf_sequencer_if.slave     bus,
    input  wire logic [W-1:0] rf_data_out,
    output logic [W-1:0]      rf_data_in,
    output logic [2:0]        rf_writenum,
    output logic [2:0]        rf_readnum,
    output logic              rf_write,
    output logic              busy
);
    localparam logic [1:0] OP_MOVI = 2'b00;
    localparam logic [1:0] OP_MOV  = 2'b01;
    localparam logic [1:0] OP_SWAP = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_IMM = 3'd1,
        S_RD_A   = 3'd2,
        S_RD_B   = 3'd3,
        S_WR_A   = 3'd4,
        S_WR_B   = 3'd5,
        S_RSP    = 3'd6
    } state_t;

    state_t       state_q;
    logic [1:0]   op_q;
    logic [2:0]   rd_q;
    logic [2:0]   rs_q;
    logic [W-1:0] tmp_a_q;
    logic [W-1:0] tmp_b_q;
    logic [W-1:0] rsp_data_q;
    logic         rsp_valid_q;
    logic         cmd_ready_q;
    logic         busy_q;
    logic         rf_write_q;
    logic [2:0]   rf_writenum_q;
    logic [2:0]   rf_readnum_q;
    logic [W-1:0] rf_data_in_q;
`ifdef RF_SEQ_SHIFT_EN
    logic [1:0]   sh_q;
`endif

    logic [W-1:0] w_imm_ext;
    logic [W-1:0] w_mov_val;

    assign w_imm_ext = {{(W-IMM_W){bus.cmd_imm[IMM_W-1]}}, bus.cmd_imm};

    // MOV write data is derived from the live read so it lands in data_in on the RD_A edge.
`ifdef RF_SEQ_SHIFT_EN
    always_comb begin
        w_mov_val = rf_data_out;
        case (sh_q)
            2'b01:   w_mov_val = {rf_data_out[W-2:0], 1'b0};
            2'b10:   w_mov_val = {1'b0, rf_data_out[W-1:1]};
            2'b11:   w_mov_val = {rf_data_out[W-1], rf_data_out[W-1:1]};
            default: w_mov_val = rf_data_out;
        endcase
    end
`else
    assign w_mov_val = rf_data_out;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            op_q          <= OP_MOVI;
            rd_q          <= 3'd0;
            rs_q          <= 3'd0;
            tmp_a_q       <= '0;
            tmp_b_q       <= '0;
            rsp_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            rf_write_q    <= 1'b0;
            rf_writenum_q <= 3'd0;
            rf_readnum_q  <= 3'd0;
            rf_data_in_q  <= '0;
`ifdef RF_SEQ_SHIFT_EN
            sh_q          <= 2'b00;
`endif
        end else begin
            // Regfile strobes are one-state pulses; each state re-asserts what it needs.
            rf_write_q    <= 1'b0;
            rf_writenum_q <= 3'd0;
            rf_readnum_q  <= 3'd0;
            rf_data_in_q  <= '0;

            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    if (bus.cmd_valid && cmd_ready_q) begin
                        op_q        <= bus.cmd_op;
                        rd_q        <= bus.cmd_rd;
                        rs_q        <= bus.cmd_rs;
`ifdef RF_SEQ_SHIFT_EN
                        sh_q        <= bus.cmd_sh;
`endif
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (bus.cmd_op == OP_MOVI) begin
                            state_q       <= S_WR_IMM;
                            rf_write_q    <= 1'b1;
                            rf_writenum_q <= bus.cmd_rd;
                            rf_data_in_q  <= w_imm_ext;
                        end else begin
                            state_q      <= S_RD_A;
                            rf_readnum_q <= bus.cmd_rs;
                        end
                    end
                end

                S_WR_IMM: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end

                S_RD_A: begin
                    tmp_a_q <= rf_data_out;
                    case (op_q)
                        OP_MOV: begin
                            state_q       <= S_WR_A;
                            rf_write_q    <= 1'b1;
                            rf_writenum_q <= rd_q;
                            rf_data_in_q  <= w_mov_val;
                        end
                        OP_SWAP: begin
                            state_q      <= S_RD_B;
                            rf_readnum_q <= rd_q;
                        end
                        OP_READ: begin
                            state_q     <= S_RSP;
                            rsp_data_q  <= rf_data_out;
                            rsp_valid_q <= 1'b1;
                        end
                        default: begin
                            state_q     <= S_IDLE;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end
                    endcase
                end

                S_RD_B: begin
                    tmp_b_q       <= rf_data_out;
                    state_q       <= S_WR_A;
                    rf_write_q    <= 1'b1;
                    rf_writenum_q <= rd_q;
                    rf_data_in_q  <= tmp_a_q;
                end

                S_WR_A: begin
                    if (op_q == OP_SWAP) begin
                        state_q       <= S_WR_B;
                        rf_write_q    <= 1'b1;
                        rf_writenum_q <= rs_q;
                        rf_data_in_q  <= tmp_b_q;
                    end else begin
                        state_q     <= S_IDLE;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end

                S_WR_B: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end

                S_RSP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign rf_write      = rf_write_q;
    assign rf_writenum   = rf_writenum_q;
    assign rf_readnum    = rf_readnum_q;
    assign rf_data_in    = rf_data_in_q;
    assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_rf_sequencer : regfile model, command-level reference model, rsp scoreboard
// Revision 1.0
// ============================================================================
module tb_rf_sequencer;
    localparam int W     = 16;
    localparam int IMM_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_sequencer_if #(.W(W), .IMM_W(IMM_W)) sif ();

    logic [W-1:0] rf_data_out;
    logic [W-1:0] rf_data_in;
    logic [2:0]   rf_writenum;
    logic [2:0]   rf_readnum;
    logic         rf_write;
    logic         busy;

    rf_sequencer #(.W(W), .IMM_W(IMM_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (sif),
        .rf_data_out (rf_data_out),
        .rf_data_in  (rf_data_in),
        .rf_writenum (rf_writenum),
        .rf_readnum  (rf_readnum),
        .rf_write    (rf_write),
        .busy        (busy)
    );

    // Register file attached to the DUT, with a back door for preloading while idle.
    logic [W-1:0] regs [8];
    logic         poke_en  = 1'b0;
    logic [2:0]   poke_idx = 3'd0;
    logic [W-1:0] poke_val = '0;
    assign rf_data_out = regs[rf_readnum];
    always @(posedge clk) begin
        if (poke_en)       regs[poke_idx]    <= poke_val;
        else if (rf_write) regs[rf_writenum] <= rf_data_in;
    end

    logic [W-1:0] model [8];
    logic [W-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int rdy_mode = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] sext(input logic [7:0] imm);
        int v;
        v = int'(imm);
        if (v >= 128) v = v + 65280;
        return W'(v);
    endfunction

    function automatic logic [W-1:0] mov_val(input logic [W-1:0] v, input logic [1:0] sh);
        int x;
        int r;
        x = int'(v);
        r = x;
`ifdef RF_SEQ_SHIFT_EN
        case (sh)
            2'd1:    r = (x * 2) % 65536;
            2'd2:    r = x / 2;
            2'd3:    r = x / 2 + ((x >= 32768) ? 32768 : 0);
            default: r = x;
        endcase
`else
        if (sh > 2'd3) r = 0;
`endif
        return W'(r);
    endfunction

    task automatic poke(input logic [2:0] i, input logic [W-1:0] v);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_idx = i;
        poke_val = v;
        @(posedge clk);
        #1 poke_en = 1'b0;
        model[i] = v;
    endtask

    // Returns #1 after the accept edge; the reference model is updated at accept.
    task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [7:0] imm, input logic [1:0] sh);
        int n;
        logic [W-1:0] t;
        @(negedge clk);
        sif.cmd_valid = 1'b1;
        sif.cmd_op    = op;
        sif.cmd_rd    = rd;
        sif.cmd_rs    = rs;
        sif.cmd_imm   = imm;
        sif.cmd_sh    = sh;
        n = 0;
        while (!sif.cmd_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!sif.cmd_ready) begin
            chk("cmd_accept_timeout", 32'd0, 32'd1);
            sif.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 sif.cmd_valid = 1'b0;
        case (op)
            2'b00: model[rd] = sext(imm);
            2'b01: model[rd] = mov_val(model[rs], sh);
            2'b10: begin
                t         = model[rd];
                model[rd] = model[rs];
                model[rs] = t;
            end
            default: exp_q.push_back(model[rs]);
        endcase
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(sif.cmd_ready && !busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!(sif.cmd_ready && !busy)) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    // Consumer-side ready, changed just after each active edge.
    initial begin
        sif.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       sif.rsp_ready = 1'($urandom_range(0, 1));
                1:       sif.rsp_ready = 1'b1;
                default: sif.rsp_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard monitor: one compare per rsp handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (sif.rsp_valid && sif.rsp_ready) begin
                if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
                else                   chk("rsp_data", 32'(sif.rsp_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [W-1:0] v4;
        sif.cmd_valid = 1'b0;
        sif.cmd_op    = 2'b00;
        sif.cmd_rd    = 3'd0;
        sif.cmd_rs    = 3'd0;
        sif.cmd_imm   = '0;
        sif.cmd_sh    = 2'b00;
        for (int i = 0; i < 8; i++) poke(3'(i), '0);

        @(negedge clk);
        chk("rst_cmd_ready", 32'(sif.cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(sif.rsp_valid), 32'd0);
        chk("rst_rf_write",  32'(rf_write), 32'd0);
        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_readnum",   32'(rf_readnum), 32'd0);
        chk("rst_writenum",  32'(rf_writenum), 32'd0);
        chk("rst_data_in",   32'(rf_data_in), 32'd0);
        chk("rst_rsp_data",  32'(sif.rsp_data), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("post_rst_cmd_ready", 32'(sif.cmd_ready), 32'd1);

        // MOVI positive and negative immediates
        rdy_mode = 1;
        issue(2'b00, 3'd3, 3'd0, 8'h7F, 2'b00);
        @(negedge clk);
        chk("movi_write_hi", 32'(rf_write), 32'd1);
        chk("movi_writenum", 32'(rf_writenum), 32'd3);
        chk("movi_data_in",  32'(rf_data_in), 32'h007F);
        @(negedge clk);
        chk("movi_write_lo", 32'(rf_write), 32'd0);
        chk("movi_r3",       32'(regs[3]), 32'h007F);
        issue(2'b00, 3'd5, 3'd0, 8'h80, 2'b00);
        @(negedge clk);
        chk("movi80_data_in", 32'(rf_data_in), 32'hFF80);
        @(negedge clk);
        chk("movi80_write_lo", 32'(rf_write), 32'd0);
        chk("movi80_r5",       32'(regs[5]), 32'hFF80);

        // MOVI, MOV, READ chain
        issue(2'b00, 3'd1, 3'd0, 8'h05, 2'b00);
        issue(2'b01, 3'd2, 3'd1, 8'h00, 2'b00);
        issue(2'b11, 3'd0, 3'd2, 8'h00, 2'b00);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sif.rsp_valid) cnt++;
        end
        chk("read_valid_cycles", 32'(cnt), 32'd1);

        // SWAP with distinct registers, then with rs==rd
        wait_idle();
        poke(3'd0, 16'h1234);
        poke(3'd7, 16'hABCD);
        issue(2'b10, 3'd7, 3'd0, 8'h00, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        chk("swap_r7_e3", 32'(regs[7]), 32'h1234);
        chk("swap_r0_e3", 32'(regs[0]), 32'h1234);
        @(posedge clk);
        #1 chk("swap_r0_e4", 32'(regs[0]), 32'hABCD);
        v4 = regs[4];
        issue(2'b10, 3'd4, 3'd4, 8'h00, 2'b00);
        wait_idle();
        chk("swap_same_r4", 32'(regs[4]), 32'(v4));

        // READ held by a stalled consumer
        rdy_mode = 2;
        issue(2'b11, 3'd0, 3'd3, 8'h00, 2'b00);
        cnt = 0;
        while (!sif.rsp_valid && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(sif.rsp_valid), 32'd1);
            chk("hold_rsp_data",  32'(sif.rsp_data), 32'h007F);
            chk("hold_cmd_ready", 32'(sif.cmd_ready), 32'd0);
            chk("hold_busy",      32'(busy), 32'd1);
        end
        rdy_mode = 1;
        wait_idle();

        // MOV shift select
        poke(3'd1, 16'h8003);
        issue(2'b01, 3'd2, 3'd1, 8'h00, 2'b11);
        wait_idle();
`ifdef RF_SEQ_SHIFT_EN
        chk("mov_sh11", 32'(regs[2]), 32'hC001);
        issue(2'b01, 3'd2, 3'd1, 8'h00, 2'b01);
        wait_idle();
        chk("mov_sh01", 32'(regs[2]), 32'h0006);
        issue(2'b01, 3'd2, 3'd1, 8'h00, 2'b10);
        wait_idle();
        chk("mov_sh10", 32'(regs[2]), 32'h4001);
`else
        chk("mov_sh11_noshift", 32'(regs[2]), 32'h8003);
`endif

        // Reset during WR_B of a SWAP
        poke(3'd6, 16'h1111);
        poke(3'd1, 16'h2222);
        issue(2'b10, 3'd6, 3'd1, 8'h00, 2'b00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("wrb_write_hi", 32'(rf_write), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rf_write",  32'(rf_write), 32'd0);
        chk("midrst_cmd_ready", 32'(sif.cmd_ready), 32'd0);
        chk("midrst_rsp_valid", 32'(sif.rsp_valid), 32'd0);
        chk("midrst_busy",      32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("midrst_cmd_ready_after", 32'(sif.cmd_ready), 32'd1);
        chk("midrst_rd_written",  32'(regs[6]), 32'h2222);
        chk("midrst_rs_unchanged", 32'(regs[1]), 32'h2222);
        model[1] = 16'h2222;

        // Randomized traffic against the reference model
        rdy_mode = 0;
        for (int i = 0; i < 250; i++) begin
            issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
        end
        rdy_mode = 1;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("final_r%0d", i), 32'(regs[i]), 32'(model[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
